// File: rtl/awaiba_line_tx.sv
// awaiba_line_tx: buffers system pixel words and sends them as fixed-length line bursts, one burst per channel.
// Optional build macro AWB_TEST_PATTERN_EN adds pattern_mode, which sends buffer-free test-pattern bursts.
module awaiba_line_tx #(
  parameter int unsigned LINE_LEN = 250,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned GAP      = 4,
  parameter int unsigned BUF_AW   = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sync,
  input  logic [12:0] sys_data,
  input  logic        sys_valid,
  output logic        sys_ready,
  output logic [12:0] data,
  output logic        valid,
  input  logic        ready,
  output logic [1:0]  address,
  output logic        busy,
`ifdef AWB_TEST_PATTERN_EN
  input  logic        pattern_mode,
`endif
  output logic        frame_done
);

  localparam int unsigned DW    = 13;
  localparam int unsigned DEPTH = 1 << BUF_AW;
  localparam int unsigned CNT_W = BUF_AW + 1;
  localparam int unsigned WC_W  = $clog2(LINE_LEN + 1);
  localparam int unsigned GC_W  = $clog2(GAP);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_GAP
  } state_t;

  // Line buffer
  logic [DW-1:0]     mem [DEPTH];
  logic [BUF_AW-1:0] wr_ptr;
  logic [BUF_AW-1:0] rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              push;
  logic              pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign sys_ready = ~full & ~reset;
  assign push      = sys_valid & sys_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sys_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + BUF_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + BUF_AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Test-pattern select; tied off when the feature is not built
  logic pat_in;
  logic pat_q;
  logic pat_d;

`ifdef AWB_TEST_PATTERN_EN
  assign pat_in = pattern_mode;
`else
  assign pat_in = 1'b0;
`endif

  state_t            state;
  state_t            state_d;
  logic [WC_W-1:0]   word_cnt;
  logic [WC_W-1:0]   word_cnt_d;
  logic [GC_W-1:0]   gap_cnt;
  logic [GC_W-1:0]   gap_cnt_d;
  logic [DW-1:0]     data_d;
  logic              valid_d;
  logic [1:0]        address_d;
  logic              frame_done_d;
  logic              busy_d;
  logic              start;

  assign start = sync & ready & (pat_in | (count >= CNT_W'(LINE_LEN)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      word_cnt   <= '0;
      gap_cnt    <= '0;
      data       <= '0;
      valid      <= 1'b0;
      address    <= 2'd0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      pat_q      <= 1'b0;
    end else begin
      state      <= state_d;
      word_cnt   <= word_cnt_d;
      gap_cnt    <= gap_cnt_d;
      data       <= data_d;
      valid      <= valid_d;
      address    <= address_d;
      frame_done <= frame_done_d;
      busy       <= busy_d;
      pat_q      <= pat_d;
    end
  end

  // Next-state and registered-output values; valid must never drop inside a line
  always_comb begin
    state_d      = state;
    word_cnt_d   = word_cnt;
    gap_cnt_d    = gap_cnt;
    data_d       = data;
    valid_d      = 1'b0;
    address_d    = address;
    frame_done_d = 1'b0;
    pat_d        = pat_q;
    pop          = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (!sync) begin
          address_d = 2'd0;
        end else if (start) begin
          state_d    = ST_BURST;
          valid_d    = 1'b1;
          word_cnt_d = WC_W'(1);
          pat_d      = pat_in;
          data_d     = pat_in ? {address, 11'd0} : mem[rd_ptr];
          pop        = ~pat_in;
        end
      end

      ST_BURST: begin
        if (word_cnt == WC_W'(LINE_LEN)) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
          if (!sync) begin
            address_d = 2'd0;
          end else if (address == 2'(CHANNELS - 1)) begin
            address_d    = 2'd0;
            frame_done_d = 1'b1;
          end else begin
            address_d = address + 2'd1;
          end
        end else begin
          valid_d    = 1'b1;
          word_cnt_d = word_cnt + WC_W'(1);
          data_d     = pat_q ? {address, 11'(word_cnt)} : mem[rd_ptr];
          pop        = ~pat_q;
        end
      end

      ST_GAP: begin
        if (!sync) begin
          address_d = 2'd0;
        end
        if (gap_cnt == GC_W'(GAP - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt + GC_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_awaiba_line_tx.sv
// Directed self-checking bench for awaiba_line_tx; the pattern test is built only with AWB_TEST_PATTERN_EN.
module tb_awaiba_line_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        sync;
  logic [12:0] sys_data;
  logic        sys_valid;
  logic        sys_ready;
  logic [12:0] data;
  logic        valid;
  logic        ready;
  logic [1:0]  address;
  logic        busy;
  logic        frame_done;
`ifdef AWB_TEST_PATTERN_EN
  logic        pattern_mode;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  awaiba_line_tx dut (
    .clk        (clk),
    .reset      (reset),
    .sync       (sync),
    .sys_data   (sys_data),
    .sys_valid  (sys_valid),
    .sys_ready  (sys_ready),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .address    (address),
    .busy       (busy),
`ifdef AWB_TEST_PATTERN_EN
    .pattern_mode(pattern_mode),
`endif
    .frame_done (frame_done)
  );

  // Push n words base, base+1, ... honouring sys_ready; returns on a negedge with sys_valid low
  task automatic push_seq(input int base, input int n);
    int sent  = 0;
    int guard = 0;
    while (sent < n && guard < 4 * n + 1000) begin
      @(negedge clk);
      if (sys_ready) begin
        sys_valid = 1'b1;
        sys_data  = 13'(base + sent);
        sent++;
      end else begin
        sys_valid = 1'b0;
      end
      guard++;
    end
    @(negedge clk);
    sys_valid = 1'b0;
  endtask

  // Wait for a burst and record it; returns on the gap-entry negedge
  task automatic capture_burst(input logic [12:0] first, input int drop_at,
                               output int lat, output int nwords, output int errs,
                               output logic [1:0] ch, output logic [1:0] ch_gap,
                               output logic fd_burst, output logic fd_gap);
    lat = 0; nwords = 0; errs = 0; ch = 2'd0; ch_gap = 2'd0; fd_burst = 1'b0; fd_gap = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (valid !== 1'b1 && lat < 600);
    if (valid === 1'b1) begin
      ch = address;
      while (valid === 1'b1 && nwords < 300) begin
        if (data !== 13'(first + nwords)) errs++;
        if (address !== ch) errs++;
        if (frame_done) fd_burst = 1'b1;
        nwords++;
        if (nwords == drop_at) sync = 1'b0;
        @(negedge clk);
      end
      ch_gap = address;
      fd_gap = frame_done;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; sync = 1'b0; sys_valid = 1'b0; sys_data = '0; ready = 1'b0;
`ifdef AWB_TEST_PATTERN_EN
    pattern_mode = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (data !== 13'd0) begin failures++; $display("FAIL reset_data got=%0h exp=0", data); end
    checks++; if (address !== 2'd0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl got=addr%0d busy%b fd%b exp=addr0 busy0 fd0", address, busy, frame_done);
    end
    checks++; if (sys_ready !== 1'b0) begin failures++; $display("FAIL reset_sys_ready got=%b exp=0", sys_ready); end
    reset = 1'b0;
    #1;
    checks++; if (sys_ready !== 1'b1) begin failures++; $display("FAIL post_reset_sys_ready got=%b exp=1", sys_ready); end
  endtask

  task automatic test_single_line();
    int lat, n, errs, bad;
    logic [1:0] ch, chg;
    logic fdb, fdg;
    push_seq(0, 250);
    sync = 1'b1; ready = 1'b1;
    capture_burst(13'd0, 0, lat, n, errs, ch, chg, fdb, fdg);
    checks++; if (lat != 1) begin failures++; $display("FAIL line_latency got=%0d exp=1", lat); end
    checks++; if (n != 250) begin failures++; $display("FAIL line_words got=%0d exp=250", n); end
    checks++; if (errs != 0) begin failures++; $display("FAIL line_data_errs got=%0d exp=0", errs); end
    checks++; if (ch !== 2'd0 || chg !== 2'd1) begin
      failures++; $display("FAIL line_address got=%0d->%0d exp=0->1", ch, chg);
    end
    checks++; if (data !== 13'd249 || busy !== 1'b1 || fdg !== 1'b0) begin
      failures++; $display("FAIL gap_entry got=data%0d busy%b fd%b exp=data249 busy1 fd0", data, busy, fdg);
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (valid !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL gap_body got=%0d bad cycles exp=0", bad); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || valid !== 1'b0) begin
      failures++; $display("FAIL gap_end got=busy%b valid%b exp=busy0 valid0", busy, valid);
    end
  endtask

  task automatic test_frame();
    int rises[$];
    logic [1:0] addrs[$];
    int fd_idx[$];
    int nvalid = 0;
    int derr   = 0;
    logic prev_v = 1'b0;
    int sp_bad = 0;
    sync = 1'b0;
    @(negedge clk);
    sync = 1'b1; ready = 1'b1;
    fork
      push_seq(1000, 1000);
      begin
        for (int t = 0; t < 1400; t++) begin
          @(negedge clk);
          if (valid && !prev_v) begin
            rises.push_back(t);
            addrs.push_back(address);
          end
          if (valid) begin
            if (data !== 13'(1000 + nvalid)) derr++;
            nvalid++;
          end
          if (frame_done) fd_idx.push_back(t);
          prev_v = valid;
        end
      end
    join
    checks++; if (rises.size() != 4) begin failures++; $display("FAIL frame_bursts got=%0d exp=4", rises.size()); end
    checks++; if (nvalid != 1000 || derr != 0) begin
      failures++; $display("FAIL frame_data got=%0d words %0d errs exp=1000 words 0 errs", nvalid, derr);
    end
    if (rises.size() == 4) begin
      for (int i = 1; i < 4; i++) if (rises[i] - rises[i-1] != 255) sp_bad++;
      checks++; if (sp_bad != 0) begin failures++; $display("FAIL frame_spacing got=%0d bad gaps exp=0", sp_bad); end
      checks++; if (addrs[0] !== 2'd0 || addrs[1] !== 2'd1 || addrs[2] !== 2'd2 || addrs[3] !== 2'd3) begin
        failures++; $display("FAIL frame_channels got=%0d%0d%0d%0d exp=0123", addrs[0], addrs[1], addrs[2], addrs[3]);
      end
      checks++; if (fd_idx.size() != 1 || fd_idx[0] != rises[3] + 250) begin
        failures++; $display("FAIL frame_done_pulse got=%0d pulses exp=1 at gap entry of burst 4", fd_idx.size());
      end
    end
    checks++; if (address !== 2'd0) begin failures++; $display("FAIL frame_wrap got=%0d exp=0", address); end
  endtask

  task automatic test_ready_stall();
    int lat, n, errs, bad;
    logic [1:0] ch, chg;
    logic fdb, fdg;
    sync = 1'b0; ready = 1'b0;
    push_seq(3000, 250);
    sync = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL stall_idle got=%0d bad cycles exp=0", bad); end
    ready = 1'b1;
    capture_burst(13'd3000, 0, lat, n, errs, ch, chg, fdb, fdg);
    checks++; if (lat != 1) begin failures++; $display("FAIL stall_latency got=%0d exp=1", lat); end
    checks++; if (n != 250 || errs != 0) begin
      failures++; $display("FAIL stall_burst got=%0d words %0d errs exp=250 words 0 errs", n, errs);
    end
  endtask

  task automatic test_sync_drop();
    int lat, n, errs;
    logic [1:0] ch, chg;
    logic fdb, fdg;
    push_seq(4000, 250);
    capture_burst(13'd4000, 0, lat, n, errs, ch, chg, fdb, fdg);
    checks++; if (ch !== 2'd1 || chg !== 2'd2 || n != 250 || errs != 0) begin
      failures++; $display("FAIL ch1_burst got=ch%0d->%0d n%0d e%0d exp=ch1->2 n250 e0", ch, chg, n, errs);
    end
    push_seq(5000, 250);
    capture_burst(13'd5000, 100, lat, n, errs, ch, chg, fdb, fdg);
    checks++; if (ch !== 2'd2) begin failures++; $display("FAIL drop_channel got=%0d exp=2", ch); end
    checks++; if (n != 250 || errs != 0) begin
      failures++; $display("FAIL drop_words got=%0d words %0d errs exp=250 words 0 errs", n, errs);
    end
    checks++; if (chg !== 2'd0 || fdb !== 1'b0 || fdg !== 1'b0) begin
      failures++; $display("FAIL drop_gap got=addr%0d fd%b%b exp=addr0 fd00", chg, fdb, fdg);
    end
  endtask

  task automatic test_overflow_reset();
    int acc = 0;
    int lat, n, errs, wait_c, derr, bad;
    logic [1:0] ch, chg;
    logic fdb, fdg;
    sync = 1'b0; ready = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (sys_ready) begin
        sys_data = 13'(acc);
        acc++;
      end
      sys_valid = 1'b1;
    end
    @(negedge clk);
    sys_valid = 1'b0;
    checks++; if (acc != 512) begin failures++; $display("FAIL fill_count got=%0d exp=512", acc); end
    checks++; if (sys_ready !== 1'b0) begin failures++; $display("FAIL full_sys_ready got=%b exp=0", sys_ready); end
    sync = 1'b1;
    wait_c = 0;
    do begin
      @(negedge clk);
      wait_c++;
    end while (valid !== 1'b1 && wait_c < 20);
    derr = 0;
    for (int i = 0; i < 100; i++) begin
      if (valid !== 1'b1 || data !== 13'(i)) derr++;
      if (i < 99) @(negedge clk);
    end
    checks++; if (derr != 0) begin failures++; $display("FAIL full_burst_head got=%0d errs exp=0", derr); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (valid !== 1'b0 || sys_ready !== 1'b0) begin
      failures++; $display("FAIL mid_reset got=valid%b rdy%b exp=valid0 rdy0", valid, sys_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (valid !== 1'b0 || sys_ready !== 1'b1 || busy !== 1'b0 || address !== 2'd0) begin
      failures++; $display("FAIL after_reset got=valid%b rdy%b busy%b addr%0d exp=0 1 0 0", valid, sys_ready, busy, address);
    end
    push_seq(7000, 249);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL buffer_emptied got=%0d valid cycles exp=0", bad); end
    push_seq(7249, 1);
    capture_burst(13'd7000, 0, lat, n, errs, ch, chg, fdb, fdg);
    checks++; if (n != 250 || errs != 0 || ch !== 2'd0) begin
      failures++; $display("FAIL refill_burst got=n%0d e%0d ch%0d exp=n250 e0 ch0", n, errs, ch);
    end
  endtask

`ifdef AWB_TEST_PATTERN_EN
  task automatic test_pattern();
    int lat, n, errs, bad;
    logic [1:0] ch, chg;
    logic fdb, fdg;
    sync = 1'b0; ready = 1'b1;
    repeat (6) @(negedge clk);
    pattern_mode = 1'b1;
    sync = 1'b1;
    capture_burst(13'h0000, 0, lat, n, errs, ch, chg, fdb, fdg);
    checks++; if (ch !== 2'd0 || n != 250 || errs != 0) begin
      failures++; $display("FAIL pattern_ch0 got=ch%0d n%0d e%0d exp=ch0 n250 e0", ch, n, errs);
    end
    capture_burst(13'h0800, 0, lat, n, errs, ch, chg, fdb, fdg);
    sync = 1'b0;
    pattern_mode = 1'b0;
    checks++; if (ch !== 2'd1 || n != 250 || errs != 0) begin
      failures++; $display("FAIL pattern_ch1 got=ch%0d n%0d e%0d exp=ch1 n250 e0", ch, n, errs);
    end
    repeat (6) @(negedge clk);
    sync = 1'b1;
    push_seq(8000, 249);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL pattern_count got=%0d valid cycles exp=0", bad); end
    push_seq(8249, 1);
    capture_burst(13'd8000, 0, lat, n, errs, ch, chg, fdb, fdg);
    checks++; if (n != 250 || errs != 0) begin
      failures++; $display("FAIL pattern_after got=n%0d e%0d exp=n250 e0", n, errs);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_line();
    test_frame();
    test_ready_stall();
    test_sync_drop();
    test_overflow_reset();
`ifdef AWB_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
